fb_fill_ctrl: RTL and testbench

FB_FILL_CTRL -- requirements
Module: fb_fill_ctrl

---
 rtl/fb_pkg.sv | 35 +++
 rtl/fb_rr_arbiter.sv | 42 ++++
 rtl/fb_fill_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fb_fill_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer rectangle-fill controller:
//   - fill engine state encoding
//   - configuration register offsets and CTRL bit positions
//   - default framebuffer geometry
//   - pixel (x, y) to framebuffer byte address packing
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int H_MAX_DEFAULT = 640;
    localparam int V_MAX_DEFAULT = 480;

    // Configuration register offsets (cfg_addr)
    localparam logic [1:0] REG_P0    = 2'd0;
    localparam logic [1:0] REG_P1    = 2'd1;
    localparam logic [1:0] REG_COLOR = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    // Pixel index lives in byte-address bits [19:1]: x above y, halfword aligned.
    function automatic logic [31:0] fb_pixel_addr(input logic [9:0] x, input logic [8:0] y);
        return {12'b0, x, y, 1'b0};
    endfunction

endpackage

// File: rtl/fb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fb_rr_arbiter
// Two-requester round-robin arbiter for the shared framebuffer port.
//   clock, reset : clock and asynchronous active-high reset
//   req[1:0]     : requests (bit 0 = CPU, bit 1 = fill engine)
//   gnt[1:0]     : one-hot grant, same bit order as req
// A lone requester is always granted. When both request, the one that did not
// win the previous contended cycle is granted; the CPU wins first after reset.
// -----------------------------------------------------------------------------
module fb_rr_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Requester favoured in the next contended cycle: 0 = CPU, 1 = engine.
    logic prio;

    always_comb begin
        // NOTE: assign a default first so every path drives gnt and no latch is inferred.
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // The pointer only moves on contention, so uncontended traffic cannot
    // steal the next turn from the other requester.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            prio <= 1'b0;
        end else if (req == 2'b11) begin
            prio <= ~prio;
        end
    end

endmodule

// File: rtl/fb_fill_ctrl.sv
// -----------------------------------------------------------------------------
// fb_fill_ctrl
// Rectangle fill engine sharing a framebuffer write port with a CPU.
//   clock, reset          : clock and asynchronous active-high reset
//   cpu_sel/we/addr/din   : CPU framebuffer access, passed straight to fb_*
//   cpu_ready             : CPU write accepted this cycle
//   cfg_we/addr/din       : register writes (P0, P1, COLOR, CTRL)
//   fb_sel/we/addr/din    : framebuffer port
//   busy                  : fill in progress (FILL or DONE)
//   done_irq              : one-cycle pulse when a fill completes
// The engine writes every pixel of the rectangle P0..P1 inclusive, x outer
// loop, y inner loop, one pixel per cycle in which it holds the port.
// -----------------------------------------------------------------------------
module fb_fill_ctrl
    import fb_pkg::*;
#(
    parameter int H_MAX = H_MAX_DEFAULT,
    parameter int V_MAX = V_MAX_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_sel,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic        cpu_ready,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_din,
    output logic        fb_sel,
    output logic        fb_we,
    output logic [31:0] fb_addr,
    output logic [31:0] fb_din,
    output logic        busy,
    output logic        done_irq
);

    localparam logic [9:0] X_LIM = 10'(H_MAX - 1);
    localparam logic [9:0] Y_LIM = 10'(V_MAX - 1);

    fill_state_t state, state_next;

    logic [9:0]  x0, x1, x_cnt;
    logic [8:0]  y0, y1, y_cnt;
    logic [11:0] color;

    logic [9:0]  cfg_x;
    logic [9:0]  cfg_y_raw;
    logic [8:0]  cfg_y;
    logic        ctrl_wr, start_req, abort_req;
    logic        rect_empty, last_pixel;
    logic        cpu_req, eng_req, eng_gnt;
    logic [1:0]  gnt;

    // Only a subset of cfg_din carries register fields.
    logic unused_cfg_bits;
    assign unused_cfg_bits = &{1'b0, cfg_din[31:26], cfg_din[15:12]};

    // Coordinates saturate at the screen edge as they are written. y is read
    // as a 10-bit value so over-range writes such as 600 saturate rather than wrap.
    assign cfg_y_raw = cfg_din[25:16];
    assign cfg_x     = (cfg_din[9:0] > X_LIM) ? X_LIM : cfg_din[9:0];
    assign cfg_y     = (cfg_y_raw > Y_LIM) ? Y_LIM[8:0] : cfg_y_raw[8:0];

    assign ctrl_wr    = cfg_we && (cfg_addr == REG_CTRL);
    assign start_req  = ctrl_wr && cfg_din[CTRL_START] && (state == IDLE);
    assign abort_req  = ctrl_wr && cfg_din[CTRL_ABORT];
    assign rect_empty = (x1 < x0) || (y1 < y0);
    assign last_pixel = (x_cnt == x1) && (y_cnt == y1);

    assign busy     = (state != IDLE);
    assign done_irq = (state == DONE);

    // ------------------------------------------------------------------
    // Port arbitration
    // ------------------------------------------------------------------
    assign cpu_req = cpu_sel && cpu_we;
    assign eng_req = (state == FILL);

    fb_rr_arbiter u_arb (
        .clock (clock),
        .reset (reset),
        .req   ({eng_req, cpu_req}),
        .gnt   (gnt)
    );

    assign eng_gnt   = gnt[1];
    // The CPU is only held off when the engine wins a contended cycle.
    assign cpu_ready = gnt[0] || !cpu_req;

    // CPU traffic passes straight through; the engine's address and data come
    // from the scan counters and COLOR register.
    always_comb begin
        fb_sel  = cpu_sel;
        fb_we   = cpu_we;
        fb_addr = cpu_addr;
        fb_din  = cpu_din;
        if (eng_gnt) begin
            fb_sel  = 1'b1;
            fb_we   = 1'b1;
            fb_addr = fb_pixel_addr(x_cnt, y_cnt);
            fb_din  = {20'b0, color};
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers: frozen while a fill is in progress
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x0    <= '0;
            y0    <= '0;
            x1    <= '0;
            y1    <= '0;
            color <= '0;
        end else if (cfg_we && (state == IDLE)) begin
            case (cfg_addr)
                REG_P0: begin
                    x0 <= cfg_x;
                    y0 <= cfg_y;
                end
                REG_P1: begin
                    x1 <= cfg_x;
                    y1 <= cfg_y;
                end
                REG_COLOR: color <= cfg_din[11:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fill FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_req) begin
                    state_next = rect_empty ? DONE : FILL;
                end
            end
            FILL: begin
                // Abort beats completion: an aborted fill never raises done_irq.
                if (abort_req) begin
                    state_next = IDLE;
                end else if (eng_gnt && last_pixel) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scan counters: loaded on start, stepped only when the engine owns the port.
    // x_cnt steps past x1 after the last pixel; the FSM has left FILL by then.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (start_req) begin
            x_cnt <= x0;
            y_cnt <= y0;
        end else if (eng_req && eng_gnt) begin
            if (y_cnt == y1) begin
                y_cnt <= y0;
                x_cnt <= x_cnt + 10'd1;
            end else begin
                y_cnt <= y_cnt + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_fill_ctrl
// Self-checking bench for fb_fill_ctrl. A negedge monitor logs every engine
// write (CPU addresses always carry bit 31 so the two sources are told apart)
// and every done_irq cycle; expected pixel lists come from a plain nested-loop
// rectangle model with saturating coordinates.
// -----------------------------------------------------------------------------
module tb_fb_fill_ctrl;
    import fb_pkg::*;

    localparam int H = 640;
    localparam int V = 480;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_sel, cpu_we;
    logic [31:0] cpu_addr, cpu_din;
    logic        cpu_ready;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_din;
    logic        fb_sel, fb_we;
    logic [31:0] fb_addr, fb_din;
    logic        busy, done_irq;

    always #5 clock = ~clock;

    fb_fill_ctrl #(.H_MAX(H), .V_MAX(V)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_sel   (cpu_sel),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_ready (cpu_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_din   (cfg_din),
        .fb_sel    (fb_sel),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_din    (fb_din),
        .busy      (busy),
        .done_irq  (done_irq)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit stop;

    logic [31:0] eng_addr[$];
    logic [31:0] eng_data[$];
    int          eng_cyc[$];
    int          done_q[$];
    int          cpu_seen = 0;
    logic [31:0] exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (fb_sel && fb_we) begin
            if (fb_addr[31]) begin
                cpu_seen <= cpu_seen + 1;
            end else begin
                eng_addr.push_back(fb_addr);
                eng_data.push_back(fb_din);
                eng_cyc.push_back(cyc);
            end
        end
        if (done_irq) done_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Stimulus helpers and reference model
    // ---------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_din  = d;
        tick();
        cfg_we  = 1'b0;
        cfg_din = '0;
    endtask

    function automatic logic [31:0] xy(input int x, input int y);
        logic [31:0] d;
        d = '0;
        d[9:0]   = x[9:0];
        d[25:16] = y[9:0];
        return d;
    endfunction

    // Returns the edge count of the start write; the cycle that follows it carries that number.
    task automatic start_fill(output int s);
        cfg_write(REG_CTRL, 32'h1);
        s = cyc;
    endtask

    task automatic wait_idle(input int budget, input string tag, output int idle_cyc);
        for (int i = 0; i < budget && busy; i++) @(negedge clock);
        idle_cyc = cyc;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, budget);
        end
        tick();
    endtask

    function automatic int clip(input int v, input int n);
        return (v > n - 1) ? n - 1 : v;
    endfunction

    // Pixels of the rectangle in write order: x outer, y inner.
    task automatic model_fill(input int xa, input int ya, input int xb, input int yb);
        int cx0, cy0, cx1, cy1;
        cx0 = clip(xa & 1023, H);
        cy0 = clip(ya & 1023, V);
        cx1 = clip(xb & 1023, H);
        cy1 = clip(yb & 1023, V);
        exp_q.delete();
        if (cx1 < cx0 || cy1 < cy0) return;
        for (int x = cx0; x <= cx1; x++)
            for (int y = cy0; y <= cy1; y++)
                exp_q.push_back(32'(x * 1024 + y * 2));
    endtask

    // ---------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done_irq !== 1'b0)  begin n_err++; $display("FAIL reset_done_irq: got %b want 0", done_irq); end
        n_cmp++; if (fb_sel !== 1'b0)    begin n_err++; $display("FAIL reset_fb_sel: got %b want 0", fb_sel); end
        n_cmp++; if (fb_we !== 1'b0)     begin n_err++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
        n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL reset_cpu_ready: got %b want 1", cpu_ready); end
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8000_1234; cpu_din = 32'h0000_05A5;
        #1;
        n_cmp++; if (fb_addr !== 32'h8000_1234) begin n_err++; $display("FAIL cpu_pass_addr: got %h want 80001234", fb_addr); end
        n_cmp++; if (fb_din !== 32'h0000_05A5)  begin n_err++; $display("FAIL cpu_pass_din: got %h want 000005a5", fb_din); end
        n_cmp++; if (fb_we !== 1'b1)            begin n_err++; $display("FAIL cpu_pass_we: got %b want 1", fb_we); end
        n_cmp++; if (cpu_ready !== 1'b1)        begin n_err++; $display("FAIL cpu_pass_ready: got %b want 1", cpu_ready); end
        cpu_sel = 1'b0; cpu_we = 1'b0;
        @(negedge clock) reset = 1'b0;
        tick();
    endtask

    task automatic test_small_fill();
        logic [31:0] want[4];
        int base, dbase, s, idle;
        want  = '{32'h0000_0806, 32'h0000_0808, 32'h0000_0C06, 32'h0000_0C08};
        base  = eng_addr.size();
        dbase = done_q.size();
        cfg_write(REG_P0, xy(2, 3));
        cfg_write(REG_P1, xy(3, 4));
        cfg_write(REG_COLOR, 32'h0000_0F00);
        start_fill(s);
        wait_idle(50, "small", idle);
        n_cmp++; if (eng_addr.size() - base !== 4) begin n_err++; $display("FAIL small_count: got %0d want 4", eng_addr.size() - base); end
        for (int i = 0; i < 4 && base + i < eng_addr.size(); i++) begin
            n_cmp++; if (eng_addr[base+i] !== want[i]) begin n_err++; $display("FAIL small_addr[%0d]: got %h want %h", i, eng_addr[base+i], want[i]); end
            n_cmp++; if (eng_data[base+i] !== 32'h0000_0F00) begin n_err++; $display("FAIL small_data[%0d]: got %h want 00000f00", i, eng_data[base+i]); end
            n_cmp++; if (eng_cyc[base+i] !== s + i) begin n_err++; $display("FAIL small_cycle[%0d]: got %0d want %0d", i, eng_cyc[base+i], s + i); end
        end
        n_cmp++; if (done_q.size() - dbase !== 1) begin n_err++; $display("FAIL small_done_count: got %0d want 1", done_q.size() - dbase); end
        else begin
            n_cmp++; if (done_q[dbase] !== s + 4) begin n_err++; $display("FAIL small_done_cycle: got %0d want %0d", done_q[dbase], s + 4); end
        end
        n_cmp++; if (idle !== s + 5) begin n_err++; $display("FAIL small_busy_fall: got %0d want %0d", idle, s + 5); end
    endtask

    task automatic test_empty();
        int base, dbase, s, idle;
        base  = eng_addr.size();
        dbase = done_q.size();
        cfg_write(REG_P0, xy(10, 10));
        cfg_write(REG_P1, xy(9, 10));
        start_fill(s);
        wait_idle(20, "empty", idle);
        n_cmp++; if (eng_addr.size() - base !== 0) begin n_err++; $display("FAIL empty_count: got %0d want 0", eng_addr.size() - base); end
        n_cmp++; if (done_q.size() - dbase !== 1) begin n_err++; $display("FAIL empty_done_count: got %0d want 1", done_q.size() - dbase); end
        else begin
            n_cmp++; if (done_q[dbase] !== s) begin n_err++; $display("FAIL empty_done_cycle: got %0d want %0d", done_q[dbase], s); end
        end
        n_cmp++; if (idle !== s + 1) begin n_err++; $display("FAIL empty_busy_fall: got %0d want %0d", idle, s + 1); end
    endtask

    task automatic test_contention();
        int base, dbase, s, idle;
        logic want_ready;
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        tick();
        base  = eng_addr.size();
        dbase = done_q.size();
        cfg_write(REG_P0, xy(5, 6));
        cfg_write(REG_P1, xy(6, 7));
        cfg_write(REG_COLOR, 32'h0000_00F0);
        model_fill(5, 6, 6, 7);
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8000_0100; cpu_din = 32'h0000_0ABC;
        start_fill(s);
        // CPU wins the first contended cycle after reset, then turns alternate.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            want_ready = (i % 2 == 0);
            n_cmp++; if (cpu_ready !== want_ready) begin n_err++; $display("FAIL cont_ready[%0d]: got %b want %b", i, cpu_ready, want_ready); end
            n_cmp++; if (fb_addr[31] !== want_ready) begin n_err++; $display("FAIL cont_owner[%0d]: got cpu=%b want cpu=%b", i, fb_addr[31], want_ready); end
        end
        cpu_sel = 1'b0; cpu_we = 1'b0;
        wait_idle(40, "cont", idle);
        n_cmp++; if (eng_addr.size() - base !== exp_q.size()) begin n_err++; $display("FAIL cont_count: got %0d want %0d", eng_addr.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < eng_addr.size(); i++) begin
            n_cmp++; if (eng_addr[base+i] !== exp_q[i]) begin n_err++; $display("FAIL cont_addr[%0d]: got %h want %h", i, eng_addr[base+i], exp_q[i]); end
            n_cmp++; if (eng_cyc[base+i] !== s + 1 + 2 * i) begin n_err++; $display("FAIL cont_cycle[%0d]: got %0d want %0d", i, eng_cyc[base+i], s + 1 + 2 * i); end
        end
        n_cmp++; if (done_q.size() - dbase !== 1) begin n_err++; $display("FAIL cont_done_count: got %0d want 1", done_q.size() - dbase); end
    endtask

    task automatic test_clamp_ignore();
        int base, s, idle;
        model_fill(638, 478, 1000, 600);
        cfg_write(REG_P0, xy(638, 478));
        cfg_write(REG_P1, xy(1000, 600));
        cfg_write(REG_COLOR, 32'h0000_00A5);
        // Two passes: the second reuses registers that were written (and ignored) while busy.
        for (int pass = 0; pass < 2; pass++) begin
            base = eng_addr.size();
            start_fill(s);
            if (pass == 0) begin
                cfg_write(REG_COLOR, 32'h0000_0123);
                cfg_write(REG_P0, xy(0, 0));
            end
            wait_idle(40, "clamp", idle);
            n_cmp++; if (eng_addr.size() - base !== exp_q.size()) begin n_err++; $display("FAIL clamp_count[%0d]: got %0d want %0d", pass, eng_addr.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && base + i < eng_addr.size(); i++) begin
                n_cmp++; if (eng_addr[base+i] !== exp_q[i]) begin n_err++; $display("FAIL clamp_addr[%0d][%0d]: got %h want %h", pass, i, eng_addr[base+i], exp_q[i]); end
                n_cmp++; if (eng_data[base+i] !== 32'h0000_00A5) begin n_err++; $display("FAIL clamp_data[%0d][%0d]: got %h want 000000a5", pass, i, eng_data[base+i]); end
            end
        end
    endtask

    task automatic test_abort();
        int base, dbase, s, n;
        base  = eng_addr.size();
        dbase = done_q.size();
        cfg_write(REG_P0, xy(0, 0));
        cfg_write(REG_P1, xy(9, 9));
        cfg_write(REG_COLOR, 32'h0000_0777);
        model_fill(0, 0, 9, 9);
        start_fill(s);
        for (int i = 0; i < 50 && eng_addr.size() - base < 5; i++) @(negedge clock);
        cfg_write(REG_CTRL, 32'h2);
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (20) @(negedge clock);
        n = eng_addr.size() - base;
        n_cmp++; if (n < 5 || n > 6) begin n_err++; $display("FAIL abort_count: got %0d want 5..6", n); end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            n_cmp++; if (eng_addr[base+i] !== exp_q[i]) begin n_err++; $display("FAIL abort_addr[%0d]: got %h want %h", i, eng_addr[base+i], exp_q[i]); end
        end
        n_cmp++; if (done_q.size() !== dbase) begin n_err++; $display("FAIL abort_done_irq: got %0d pulses want 0", done_q.size() - dbase); end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        int base, dbase, s, n;
        base  = eng_addr.size();
        dbase = done_q.size();
        cfg_write(REG_P0, xy(20, 20));
        cfg_write(REG_P1, xy(29, 29));
        start_fill(s);
        for (int i = 0; i < 50 && eng_addr.size() - base < 3; i++) @(negedge clock);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_in_fill: busy=%b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL rstmid_fb_we: got %b want 0", fb_we); end
        n = eng_addr.size();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        n_cmp++; if (eng_addr.size() !== n) begin n_err++; $display("FAIL rstmid_writes_after: got %0d want 0", eng_addr.size() - n); end
        n_cmp++; if (done_q.size() !== dbase) begin n_err++; $display("FAIL rstmid_done_irq: got %0d pulses want 0", done_q.size() - dbase); end
        tick();
    endtask

    // CPU master that holds each write until it is accepted.
    task automatic cpu_traffic(output int issued);
        bit accepted;
        issued = 0;
        while (!stop) begin
            if (!cpu_sel && $urandom_range(0, 1) == 1) begin
                cpu_sel  = 1'b1;
                cpu_we   = 1'b1;
                cpu_addr = 32'h8000_0000 | 32'($urandom_range(0, 65535));
                cpu_din  = $urandom;
            end
            @(negedge clock);
            accepted = cpu_sel && cpu_ready;
            if (accepted) issued++;
            tick();
            if (accepted) begin
                cpu_sel = 1'b0;
                cpu_we  = 1'b0;
            end
        end
        cpu_sel = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic test_random();
        int xa, ya, xb, yb, col, base, dbase, cbase, s, idle, issued;
        for (int t = 0; t < 25; t++) begin
            xa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : int'($urandom_range(634, 700));
            ya = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : int'($urandom_range(474, 560));
            xb = xa + int'($urandom_range(0, 3));
            yb = ya + int'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0 && xa > 0) xb = xa - 1;
            if ($urandom_range(0, 5) == 0 && ya > 0) yb = ya - 1;
            col = int'($urandom_range(0, 4095));
            cfg_write(REG_P0, xy(xa, ya));
            cfg_write(REG_P1, xy(xb, yb));
            cfg_write(REG_COLOR, 32'(col));
            model_fill(xa, ya, xb, yb);
            base  = eng_addr.size();
            dbase = done_q.size();
            cbase = cpu_seen;
            stop  = 1'b0;
            fork
                begin
                    start_fill(s);
                    wait_idle(200, "rand", idle);
                    stop = 1'b1;
                end
                cpu_traffic(issued);
            join
            tick();
            n_cmp++; if (eng_addr.size() - base !== exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: got %0d want %0d", t, eng_addr.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && base + i < eng_addr.size(); i++) begin
                n_cmp++; if (eng_addr[base+i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_addr[%0d]: got %h want %h", t, i, eng_addr[base+i], exp_q[i]); end
                n_cmp++; if (eng_data[base+i] !== 32'(col)) begin n_err++; $display("FAIL rand%0d_data[%0d]: got %h want %h", t, i, eng_data[base+i], 32'(col)); end
            end
            n_cmp++; if (done_q.size() - dbase !== 1) begin n_err++; $display("FAIL rand%0d_done_count: got %0d want 1", t, done_q.size() - dbase); end
            n_cmp++; if (cpu_seen - cbase !== issued) begin n_err++; $display("FAIL rand%0d_cpu_writes: got %0d want %0d", t, cpu_seen - cbase, issued); end
        end
    endtask

    initial begin
        reset    = 1'b1;
        cpu_sel  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_din  = '0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_din  = '0;
        stop     = 1'b0;
        test_reset();
        test_small_fill();
        test_empty();
        test_contention();
        test_clamp_ignore();
        test_abort();
        test_reset_mid_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
